bwall_spawn_checker: RTL

// Upstream companion of the breakable-wall generator. Starts wall generation after the maze settles,

---
 rtl/bwall_spawn_checker_if.sv | 27 ++
 rtl/bwall_spawn_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bwall_spawn_checker_if.sv
// Bundle between the breakable-wall spawn checker, its generator and the maze map.
// The slave side is the checker; the master side drives frame/level events, candidates and map data.
interface bwall_spawn_checker_if;
  logic       level_start;
  logic       start_of_frame;
  logic [6:0] cand_x;
  logic [6:0] cand_y;
  logic       check_req;
  logic [6:0] maze_rd_x;
  logic [6:0] maze_rd_y;
  logic       maze_rd_wall;
  logic       should_generate;
  logic       check_done;
  logic       is_valid;
  logic [2:0] accepted_cnt;
  logic       all_placed;

  modport master (
    output level_start, start_of_frame, cand_x, cand_y, check_req, maze_rd_wall,
    input  maze_rd_x, maze_rd_y, should_generate, check_done, is_valid, accepted_cnt, all_placed
  );

  modport slave (
    input  level_start, start_of_frame, cand_x, cand_y, check_req, maze_rd_wall,
    output maze_rd_x, maze_rd_y, should_generate, check_done, is_valid, accepted_cnt, all_placed
  );
endinterface

// File: rtl/bwall_spawn_checker.sv
// Starts breakable-wall generation once the maze settles, then judges each proposed tile against
// the maze wall map, the pacman spawn and the walls already accepted.
module bwall_spawn_checker #(
  parameter int MAX_BWALLS    = 4,
  parameter int SETTLE_FRAMES = 2,
  parameter int MAZE_W        = 40,
  parameter int MAZE_H        = 30,
  parameter int PM_SPAWN_X    = 20,
  parameter int PM_SPAWN_Y    = 17
) (
  input  logic                  clk,
  input  logic                  resetN,
  bwall_spawn_checker_if.slave  bus
);

  localparam int FC_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [FC_W-1:0] SETTLE_LAST = FC_W'(SETTLE_FRAMES - 1);
  localparam logic [6:0] MAZE_W7 = 7'(MAZE_W);
  localparam logic [6:0] MAZE_H7 = 7'(MAZE_H);
  localparam logic [6:0] MAX_X   = 7'(MAZE_W - 1);
  localparam logic [6:0] MAX_Y   = 7'(MAZE_H - 1);
  localparam logic [6:0] SPAWN_X = 7'(PM_SPAWN_X);
  localparam logic [6:0] SPAWN_Y = 7'(PM_SPAWN_Y);
  localparam logic [2:0] MAX_CNT = 3'(MAX_BWALLS);

  localparam logic [3:0] ARM_ST    = 4'd0;
  localparam logic [3:0] WAIT_ST   = 4'd1;
  localparam logic [3:0] RD_C_ST   = 4'd2;
  localparam logic [3:0] RD_U_ST   = 4'd3;
  localparam logic [3:0] RD_D_ST   = 4'd4;
  localparam logic [3:0] RD_L_ST   = 4'd5;
  localparam logic [3:0] RD_R_ST   = 4'd6;
  localparam logic [3:0] LAST_ST   = 4'd7;
  localparam logic [3:0] DECIDE_ST = 4'd8;
  localparam logic [3:0] DONE_ST   = 4'd9;

  function automatic logic [6:0] abs_diff(input logic [6:0] a, input logic [6:0] b);
    if (a >= b) return a - b;
    else        return b - a;
  endfunction

  // Off-edge neighbours re-read the centre; their value is forced to wall on capture.
  function automatic logic [13:0] rd_addr(input logic [3:0] st, input logic [6:0] x,
                                          input logic [6:0] y);
    logic [6:0] ax;
    logic [6:0] ay;
    ax = x;
    ay = y;
    case (st)
      RD_C_ST: begin ax = x; ay = y; end
      RD_U_ST: if (y == 7'd0)  ay = y; else ay = y - 7'd1;
      RD_D_ST: if (y == MAX_Y) ay = y; else ay = y + 7'd1;
      RD_L_ST: if (x == 7'd0)  ax = x; else ax = x - 7'd1;
      RD_R_ST: if (x == MAX_X) ax = x; else ax = x + 7'd1;
      default: begin ax = 7'd0; ay = 7'd0; end
    endcase
    return {ax, ay};
  endfunction

  logic [3:0]      state_q, state_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [6:0]      cx_q, cx_d, cy_q, cy_d;
  logic            wc_q, wc_d, wu_q, wu_d, wd_q, wd_d, wl_q, wl_d;
  logic [6:0]      tab_x_q [MAX_BWALLS];
  logic [6:0]      tab_x_d [MAX_BWALLS];
  logic [6:0]      tab_y_q [MAX_BWALLS];
  logic [6:0]      tab_y_d [MAX_BWALLS];
  logic            should_generate_q, should_generate_d;
  logic            check_done_q, check_done_d;
  logic            is_valid_q, is_valid_d;
  logic [2:0]      accepted_cnt_q, accepted_cnt_d;
  logic            all_placed_q, all_placed_d;
  logic [6:0]      maze_rd_x_q, maze_rd_x_d, maze_rd_y_q, maze_rd_y_d;

  logic            wr_s, near_s, corridor_s, valid_s;

  // Verdict for the latched candidate; the right-neighbour bit arrives live during LAST_ST.
  always_comb begin
    wr_s   = (cx_q == MAX_X) | bus.maze_rd_wall;
    near_s = 1'b0;
    for (int i = 0; i < MAX_BWALLS; i++) begin
      if ((3'(i) < accepted_cnt_q) && (abs_diff(cx_q, tab_x_q[i]) <= 7'd1) &&
          (abs_diff(cy_q, tab_y_q[i]) <= 7'd1)) near_s = 1'b1;
      else near_s = near_s;
    end
    corridor_s = (wu_q & wd_q & ~wl_q & ~wr_s) | (wl_q & wr_s & ~wu_q & ~wd_q);
    valid_s    = (cx_q < MAZE_W7) & (cy_q < MAZE_H7) & ~wc_q & corridor_s &
                 ~((cx_q == SPAWN_X) & (cy_q == SPAWN_Y)) & ~near_s;
  end

  // Sequencing, read capture, table update and next-cycle output values.
  always_comb begin
    state_d           = state_q;
    frame_cnt_d       = frame_cnt_q;
    cx_d              = cx_q;
    cy_d              = cy_q;
    wc_d              = wc_q;
    wu_d              = wu_q;
    wd_d              = wd_q;
    wl_d              = wl_q;
    tab_x_d           = tab_x_q;
    tab_y_d           = tab_y_q;
    should_generate_d = 1'b0;
    check_done_d      = 1'b0;
    is_valid_d        = is_valid_q;
    accepted_cnt_d    = accepted_cnt_q;
    case (state_q)
      ARM_ST: begin
        if (bus.start_of_frame) begin
          if (frame_cnt_q == SETTLE_LAST) begin
            should_generate_d = 1'b1;
            frame_cnt_d       = '0;
            state_d           = WAIT_ST;
          end else begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      WAIT_ST: begin
        if (bus.check_req) begin
          cx_d    = bus.cand_x;
          cy_d    = bus.cand_y;
          state_d = RD_C_ST;
        end else begin
          state_d = WAIT_ST;
        end
      end
      RD_C_ST: state_d = RD_U_ST;
      RD_U_ST: begin wc_d = bus.maze_rd_wall;                        state_d = RD_D_ST; end
      RD_D_ST: begin wu_d = (cy_q == 7'd0)  | bus.maze_rd_wall;      state_d = RD_L_ST; end
      RD_L_ST: begin wd_d = (cy_q == MAX_Y) | bus.maze_rd_wall;      state_d = RD_R_ST; end
      RD_R_ST: begin wl_d = (cx_q == 7'd0)  | bus.maze_rd_wall;      state_d = LAST_ST; end
      LAST_ST: begin
        check_done_d = 1'b1;
        is_valid_d   = valid_s;
        if (valid_s) begin
          accepted_cnt_d = accepted_cnt_q + 3'd1;
          for (int i = 0; i < MAX_BWALLS; i++) begin
            if (3'(i) == accepted_cnt_q) begin
              tab_x_d[i] = cx_q;
              tab_y_d[i] = cy_q;
            end else begin
              tab_x_d[i] = tab_x_q[i];
              tab_y_d[i] = tab_y_q[i];
            end
          end
        end else begin
          accepted_cnt_d = accepted_cnt_q;
        end
        state_d = DECIDE_ST;
      end
      DECIDE_ST: state_d = (accepted_cnt_q == MAX_CNT) ? DONE_ST : WAIT_ST;
      DONE_ST:   state_d = DONE_ST;
      default:   state_d = ARM_ST;
    endcase

    if (bus.level_start) begin
      state_d           = ARM_ST;
      frame_cnt_d       = '0;
      accepted_cnt_d    = 3'd0;
      should_generate_d = 1'b0;
      check_done_d      = 1'b0;
      is_valid_d        = 1'b0;
      for (int i = 0; i < MAX_BWALLS; i++) begin
        tab_x_d[i] = 7'd0;
        tab_y_d[i] = 7'd0;
      end
    end else begin
      state_d = state_d;
    end

    {maze_rd_x_d, maze_rd_y_d} = rd_addr(state_d, cx_d, cy_d);
    all_placed_d               = (state_d == DONE_ST);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q           <= ARM_ST;
      frame_cnt_q       <= '0;
      cx_q              <= 7'd0;
      cy_q              <= 7'd0;
      wc_q              <= 1'b0;
      wu_q              <= 1'b0;
      wd_q              <= 1'b0;
      wl_q              <= 1'b0;
      tab_x_q           <= '{default: 7'd0};
      tab_y_q           <= '{default: 7'd0};
      should_generate_q <= 1'b0;
      check_done_q      <= 1'b0;
      is_valid_q        <= 1'b0;
      accepted_cnt_q    <= 3'd0;
      all_placed_q      <= 1'b0;
      maze_rd_x_q       <= 7'd0;
      maze_rd_y_q       <= 7'd0;
    end else begin
      state_q           <= state_d;
      frame_cnt_q       <= frame_cnt_d;
      cx_q              <= cx_d;
      cy_q              <= cy_d;
      wc_q              <= wc_d;
      wu_q              <= wu_d;
      wd_q              <= wd_d;
      wl_q              <= wl_d;
      tab_x_q           <= tab_x_d;
      tab_y_q           <= tab_y_d;
      should_generate_q <= should_generate_d;
      check_done_q      <= check_done_d;
      is_valid_q        <= is_valid_d;
      accepted_cnt_q    <= accepted_cnt_d;
      all_placed_q      <= all_placed_d;
      maze_rd_x_q       <= maze_rd_x_d;
      maze_rd_y_q       <= maze_rd_y_d;
    end
  end

  assign bus.should_generate = should_generate_q;
  assign bus.check_done      = check_done_q;
  assign bus.is_valid        = is_valid_q;
  assign bus.accepted_cnt    = accepted_cnt_q;
  assign bus.all_placed      = all_placed_q;
  assign bus.maze_rd_x       = maze_rd_x_q;
  assign bus.maze_rd_y       = maze_rd_y_q;

endmodule
